// File: rtl/bram_col_stream_reader.sv
// bram_col_stream_reader
//   Read-side sequencer for one BRAM column. A start command with a non-zero
//   length walks addresses base..base+len-1 (wrapping mod 2^ADDR_WIDTH) and
//   streams the returned words out on a valid/ready interface, flagging the
//   final word with m_last. A small first-word-fall-through FIFO absorbs the
//   BRAM read latency. Reads are only issued when a FIFO slot is guaranteed,
//   so backpressure never drops data.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   start, base_addr, len command strobe (honoured only when idle), first address, word count
//   busy, done            command in progress, one-cycle completion pulse
//   mem_rd_en             read strobe to the BRAM column
//   mem_addr_read         read address to the BRAM column
//   mem_data_out          read data from the BRAM column, RD_LATENCY cycles after the strobe
//   m_valid, m_ready      output stream handshake
//   m_data, m_last        output stream payload and end-of-command flag
module bram_col_stream_reader #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 11,
  parameter int LEN_WIDTH  = 12,
  parameter int RD_LATENCY = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [LEN_WIDTH-1:0]  len,
  output logic                  busy,
  output logic                  done,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_addr_read,
  input  logic [DATA_WIDTH-1:0] mem_data_out,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  // Wide enough for fifo_count + inflight + the read issued this cycle.
  localparam int CW = $clog2(2 * FIFO_DEPTH + 2) + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] next_addr;
  logic [LEN_WIDTH-1:0]  remaining;
  logic                  rd_last;

  logic [RD_LATENCY-1:0] pipe_vld;
  logic [RD_LATENCY-1:0] pipe_last;

  logic [DATA_WIDTH-1:0] fifo_data [FIFO_DEPTH];
  logic                  fifo_last [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [CW-1:0]         fifo_count;
  logic [CW-1:0]         inflight;

  logic                  push;
  logic                  pop;
  logic [CW-1:0]         outstanding;
  logic                  credit_ok;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // The oldest in-flight read lands in the FIFO at the end of its final stage.
  assign push        = pipe_vld[RD_LATENCY-1];
  assign m_valid     = (fifo_count != '0);
  assign pop         = m_valid && m_ready;
  // Storage is not reset, so the head is gated to give clean zeros while empty.
  assign m_data      = m_valid ? fifo_data[rd_ptr] : '0;
  assign m_last      = m_valid && fifo_last[rd_ptr];
  // The read currently on mem_rd_en already owns a slot, so it is counted too.
  assign outstanding = fifo_count + inflight + CW'(mem_rd_en);
  assign credit_ok   = (outstanding < CW'(FIFO_DEPTH));

  // Command sequencer. mem_rd_en/mem_addr_read are registered: the issue
  // decision is taken at the edge before the cycle the strobe is visible.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      mem_rd_en     <= 1'b0;
      mem_addr_read <= '0;
      next_addr     <= '0;
      remaining     <= '0;
      rd_last       <= 1'b0;
    end else begin
      done      <= 1'b0;
      mem_rd_en <= 1'b0;
      rd_last   <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            if (len != '0) begin
              // FIFO and pipeline are empty whenever we are idle, so the
              // first read needs no credit check.
              busy          <= 1'b1;
              mem_rd_en     <= 1'b1;
              mem_addr_read <= base_addr;
              next_addr     <= base_addr + ADDR_WIDTH'(1);
              remaining     <= len - LEN_WIDTH'(1);
              rd_last       <= (len == LEN_WIDTH'(1));
              state         <= (len == LEN_WIDTH'(1)) ? DRAIN : ISSUE;
            end else begin
              done <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (credit_ok) begin
            mem_rd_en     <= 1'b1;
            mem_addr_read <= next_addr;
            next_addr     <= next_addr + ADDR_WIDTH'(1);
            remaining     <= remaining - LEN_WIDTH'(1);
            rd_last       <= (remaining == LEN_WIDTH'(1));
            if (remaining == LEN_WIDTH'(1)) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (pop && m_last) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // In-flight tracking: one stage per cycle of BRAM latency, plus FIFO
  // pointers and occupancy counts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_vld   <= '0;
      pipe_last  <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      inflight   <= '0;
    end else begin
      pipe_vld[0]  <= mem_rd_en;
      pipe_last[0] <= mem_rd_en && rd_last;
      for (int i = 1; i < RD_LATENCY; i++) begin
        pipe_vld[i]  <= pipe_vld[i-1];
        pipe_last[i] <= pipe_last[i-1];
      end
      inflight <= inflight + CW'(mem_rd_en) - CW'(push);
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      unique case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // NOTE: FIFO storage has no reset; occupancy is tracked by the reset
  // counters above, and leaving the array unreset lets it map to plain
  // registers or distributed RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_ptr] <= mem_data_out;
      fifo_last[wr_ptr] <= pipe_last[RD_LATENCY-1];
    end
  end

endmodule

// File: tb/tb_bram_col_stream_reader.sv
// tb_bram_col_stream_reader
//   Directed bench for bram_col_stream_reader with a 10-bit address space,
//   RD_LATENCY=1 and a 4-entry FIFO. A BRAM model returns mem[a]=a one
//   cycle after each read strobe. A negedge monitor logs issued addresses,
//   accepted beats, done pulses and stall stability for the checks.
module tb_bram_col_stream_reader;

  localparam int DW    = 32;
  localparam int AW    = 10;
  localparam int LW    = 11;
  localparam int LAT   = 1;
  localparam int DEPTH = 4;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [LW-1:0] len;
  logic          busy;
  logic          done;
  logic          mem_rd_en;
  logic [AW-1:0] mem_addr_read;
  logic [DW-1:0] mem_data_out;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic          m_last;

  bram_col_stream_reader #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW),
    .RD_LATENCY(LAT), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .len(len),
    .busy(busy), .done(done), .mem_rd_en(mem_rd_en), .mem_addr_read(mem_addr_read),
    .mem_data_out(mem_data_out), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_last(m_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // BRAM column model: mem[a] = a, one-cycle read latency.
  always @(posedge clk) begin
    if (mem_rd_en) mem_data_out <= DW'(mem_addr_read);
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Monitor state
  int            cyc = 0;
  int            start_cyc;
  int            first_valid;
  int            done_cnt;
  int            done_cyc;
  int            issued;
  int            accepted;
  int            max_out;
  int            stall_viol;
  bit            busy_seen;
  bit            valid_seen;
  bit            stalled_prev;
  logic [DW-1:0] prev_data;
  logic          prev_last;
  logic [AW-1:0] addr_q[$];
  logic [DW-1:0] data_q[$];
  logic          last_q[$];
  int            beat_cyc[$];

  task automatic clear_mon();
    start_cyc = -1; first_valid = -1; done_cnt = 0; done_cyc = -1;
    issued = 0; accepted = 0; max_out = 0; stall_viol = 0;
    busy_seen = 0; valid_seen = 0; stalled_prev = 0;
    addr_q.delete(); data_q.delete(); last_q.delete(); beat_cyc.delete();
  endtask

  always @(negedge clk) begin
    cyc++;
    if (rst_n) begin
      if (start) start_cyc = cyc;
      if (mem_rd_en) begin
        addr_q.push_back(mem_addr_read);
        issued++;
      end
      // Reads outstanding before this cycle's pop must fit the FIFO.
      if (issued - accepted > max_out) max_out = issued - accepted;
      if (m_valid && first_valid < 0) first_valid = cyc;
      if (busy) busy_seen = 1;
      if (m_valid) valid_seen = 1;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (stalled_prev && !(m_valid && m_data == prev_data && m_last == prev_last))
        stall_viol++;
      stalled_prev = m_valid && !m_ready;
      prev_data    = m_data;
      prev_last    = m_last;
      if (m_valid && m_ready) begin
        data_q.push_back(m_data);
        last_q.push_back(m_last);
        beat_cyc.push_back(cyc);
        accepted++;
      end
    end
  end

  task automatic pulse_start(input logic [AW-1:0] b, input logic [LW-1:0] l);
    @(posedge clk); #1;
    start = 1'b1; base_addr = b; len = l;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int k = 0;
    while (done_cnt == 0 && k < budget) begin
      @(posedge clk);
      k++;
    end
    check({tag, "_done_seen"}, 64'(done_cnt > 0), 64'd1);
  endtask

  // Beats must be base, base+1, ... (mod 2^AW) with m_last only on the final one.
  task automatic check_beats(input string tag, input int b, input int n);
    int errs = 0;
    check({tag, "_beat_count"}, 64'(data_q.size()), 64'(n));
    for (int i = 0; i < data_q.size() && i < n; i++) begin
      if (data_q[i] != DW'((b + i) % (1 << AW))) errs++;
      if (last_q[i] != (i == n - 1)) errs++;
    end
    check({tag, "_beat_order_last"}, 64'(errs), 64'd0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_rd_en"}, 64'(mem_rd_en), 64'd0);
    check({tag, "_addr"}, 64'(mem_addr_read), 64'd0);
    check({tag, "_m_valid"}, 64'(m_valid), 64'd0);
    check({tag, "_m_last"}, 64'(m_last), 64'd0);
    check({tag, "_m_data"}, 64'(m_data), 64'd0);
  endtask

  initial begin
    int errs;
    rst_n = 1'b0; start = 1'b0; base_addr = '0; len = '0; m_ready = 1'b0;
    clear_mon();
    repeat (2) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // 1: base 0x3F0, len 4, always ready
    #1; m_ready = 1'b1; clear_mon();
    pulse_start(10'h3F0, 11'd4);
    wait_done("t1", 40);
    check_beats("t1", 'h3F0, 4);
    check("t1_first_valid_latency", 64'(first_valid - start_cyc), 64'd3);
    check("t1_rd_en_latency", 64'(addr_q.size() > 0), 64'd1);
    check("t1_done_after_last", 64'(done_cyc - beat_cyc[3]), 64'd1);
    check("t1_done_count", 64'(done_cnt), 64'd1);

    // 2: address wrap
    @(posedge clk); #1; clear_mon();
    pulse_start(10'h3FE, 11'd4);
    wait_done("t2", 40);
    check("t2_addr_cnt", 64'(addr_q.size()), 64'd4);
    check("t2_addr0", 64'(addr_q[0]), 64'h3FE);
    check("t2_addr1", 64'(addr_q[1]), 64'h3FF);
    check("t2_addr2", 64'(addr_q[2]), 64'h000);
    check("t2_addr3", 64'(addr_q[3]), 64'h001);
    check_beats("t2", 'h3FE, 4);

    // 3: len 16 with a 10-cycle stall mid-burst
    @(posedge clk); #1; clear_mon();
    pulse_start(10'h040, 11'd16);
    for (int k = 0; k < 50 && accepted < 4; k++) @(posedge clk);
    #1; m_ready = 1'b0;
    repeat (10) @(posedge clk);
    #1; m_ready = 1'b1;
    wait_done("t3", 100);
    check_beats("t3", 'h040, 16);
    check("t3_max_outstanding_le_depth", 64'(max_out <= DEPTH), 64'd1);
    check("t3_stall_stable", 64'(stall_viol), 64'd0);
    check("t3_done_count", 64'(done_cnt), 64'd1);

    // 4: zero-length command
    @(posedge clk); #1; clear_mon();
    pulse_start(10'h123, 11'd0);
    repeat (4) @(posedge clk);
    check("t4_done_count", 64'(done_cnt), 64'd1);
    check("t4_done_latency", 64'(done_cyc - start_cyc), 64'd1);
    check("t4_busy_never", 64'(busy_seen), 64'd0);
    check("t4_valid_never", 64'(valid_seen), 64'd0);
    check("t4_no_reads", 64'(issued), 64'd0);

    // 5a: start while busy is ignored
    #1; clear_mon();
    pulse_start(10'h100, 11'd8);
    pulse_start(10'h200, 11'd3);
    wait_done("t5a", 60);
    repeat (8) @(posedge clk);
    check_beats("t5a", 'h100, 8);
    errs = 0;
    for (int i = 0; i < addr_q.size(); i++)
      if (addr_q[i] != AW'('h100 + i)) errs++;
    check("t5a_addr_seq", 64'(errs), 64'd0);
    check("t5a_addr_cnt", 64'(addr_q.size()), 64'd8);
    check("t5a_done_count", 64'(done_cnt), 64'd1);

    // 5b: reset mid-burst, then a fresh command
    #1; clear_mon(); m_ready = 1'b0;
    pulse_start(10'h300, 11'd16);
    repeat (4) @(posedge clk);
    #1; rst_n = 1'b0;
    #1;
    check_outputs_zero("t5b_midreset");
    repeat (2) @(posedge clk);
    #1; rst_n = 1'b1; m_ready = 1'b1; clear_mon();
    pulse_start(10'h010, 11'd2);
    wait_done("t5b", 40);
    repeat (6) @(posedge clk);
    check_beats("t5b", 'h010, 2);
    check("t5b_done_count", 64'(done_cnt), 64'd1);

    // 6: len 64 at full throughput
    #1; clear_mon();
    pulse_start(10'h080, 11'd64);
    wait_done("t6", 200);
    repeat (4) @(posedge clk);
    check_beats("t6", 'h080, 64);
    check("t6_consecutive", 64'(beat_cyc[63] - beat_cyc[0]), 64'd63);
    check("t6_done_count", 64'(done_cnt), 64'd1);
    check("t6_done_after_last", 64'(done_cyc - beat_cyc[63]), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
